// File: rtl/fifo_hex_uart_tx_if.sv
// fifo_hex_uart_tx_if: FIFO read-port bundle between the debug FIFO and its drain.
// master = draining consumer, slave = FIFO read side.
interface fifo_hex_uart_tx_if;
  logic       fifo_rempty;
  logic       fifo_rinc;
  logic [7:0] fifo_rdata;

  modport master (
    input  fifo_rempty,
    input  fifo_rdata,
    output fifo_rinc
  );

  modport slave (
    output fifo_rempty,
    output fifo_rdata,
    input  fifo_rinc
  );
endinterface

// File: rtl/fifo_hex_uart_tx.sv
// fifo_hex_uart_tx: pops debug FIFO bytes and serialises them as 8N1 UART frames.
// FIFO_HEX_UART_HEX_EN defined: hex-ASCII + separators/CRLF; undefined: raw bytes.
module fifo_hex_uart_tx #(
  parameter int CLK_DIV        = 868,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic               rclk,
  input  logic               rrst_n,
  fifo_hex_uart_tx_if.master fifo,
  output logic               uart_tx,
  output logic               busy,
  output logic [15:0]        byte_cnt
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP   = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] NEXT  = 3'd4;

  logic [2:0]    r_state;
  logic          r_arm;
  logic [DW-1:0] r_div;
  logic [3:0]    r_bit;
  logic [9:0]    r_shift;
  logic [15:0]   r_byte_cnt;

  logic       w_last;
  logic [7:0] w_first;
  logic [7:0] w_next;

`ifdef FIFO_HEX_UART_HEX_EN
  localparam int LW = $clog2(BYTES_PER_LINE + 1);
  localparam logic [LW-1:0] LINE_MAX = LW'(BYTES_PER_LINE - 1);

  logic [7:0]    r_byte_q;
  logic [1:0]    r_idx;
  logic [LW-1:0] r_line;
  logic          w_eol;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n})
                       : (8'h37 + {4'h0, n});
  endfunction

  assign w_eol   = (r_line == LINE_MAX);
  assign w_last  = w_eol ? (r_idx == 2'd3)
                         : (r_idx == 2'd2);
  assign w_first = f_hex(fifo.fifo_rdata[7:4]);

  // character following the one at r_idx
  always_comb begin
    w_next = 8'h0A;
    unique case (r_idx)
      2'd0:    w_next = f_hex(r_byte_q[3:0]);
      2'd1:    w_next = w_eol ? 8'h0D : 8'h20;
      default: w_next = 8'h0A;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_byte_q <= '0;
      r_idx    <= '0;
      r_line   <= '0;
    end else begin
      if (r_state == LATCH) begin
        r_byte_q <= fifo.fifo_rdata;
        r_idx    <= '0;
      end
      if (r_state == NEXT) begin
        if (!w_last)
          r_idx <= r_idx + 2'd1;
        else
          r_line <= w_eol ? '0 : r_line + 1'b1;
      end
    end
  end
`else
  assign w_last  = 1'b1;
  assign w_first = fifo.fifo_rdata;
  assign w_next  = fifo.fifo_rdata;
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state    <= IDLE;
      r_arm      <= 1'b0;
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '1;
      r_byte_cnt <= '0;
    end else begin
      r_arm <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (r_arm && !fifo.fifo_rempty)
            r_state <= POP;
        end
        POP: r_state <= LATCH;
        LATCH: begin
          r_shift <= {1'b1, w_first, 1'b0};
          r_div   <= '0;
          r_bit   <= '0;
          r_state <= SEND;
        end
        SEND: begin
          if (r_div == DIV_MAX) begin
            r_div <= '0;
            if (r_bit == 4'd9) begin
              r_state <= NEXT;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_shift <= {1'b1, r_shift[9:1]};
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        NEXT: begin
          if (!w_last) begin
            r_shift <= {1'b1, w_next, 1'b0};
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= SEND;
          end else begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo.fifo_rinc = (r_state == POP);
  assign uart_tx  = (r_state == SEND) ? r_shift[0] : 1'b1;
  assign busy     = (r_state != IDLE);
  assign byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_fifo_hex_uart_tx.sv
// tb_fifo_hex_uart_tx: random FIFO traffic against a timeline model of the drain.
// Follows FIFO_HEX_UART_HEX_EN like the design.
module tb_fifo_hex_uart_tx;
  localparam int D   = 4;
  localparam int BPL = 4;
  localparam int P   = 10 * D + 1;

  logic        clk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        uart_tx;
  logic        busy;
  logic [15:0] byte_cnt;

  fifo_hex_uart_tx_if ff();

  fifo_hex_uart_tx #(
    .CLK_DIV(D),
    .BYTES_PER_LINE(BPL)
  ) dut (
    .rclk    (clk),
    .rrst_n  (rrst_n),
    .fifo    (ff.master),
    .uart_tx (uart_tx),
    .busy    (busy),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] fq[$];
  logic [7:0] ch[$];
  logic [7:0] rxq[$];
  logic [7:0] m_byte;
  int m_off = -1;
  int m_nf = 0;
  int m_line = 0;
  logic [15:0] m_cnt = 0;
  bit m_arm = 0;
  bit m_pend = 0;
  int rx_cnt = -1;
  logic [7:0] rx_sh;
  int cyc = 0;
  int first_pop = -1;
  int cnt_cyc = -1;
  logic [15:0] prev_cnt = 0;
  int n_rinc = 0;
  int n_txlo = 0;
  int n_busy = 0;
  string HX = "0123456789ABCDEF";

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void load_chars(logic [7:0] b);
    ch.delete();
`ifdef FIFO_HEX_UART_HEX_EN
    ch.push_back(HX[int'(b[7:4])]);
    ch.push_back(HX[int'(b[3:0])]);
    if (m_line == BPL - 1) begin
      ch.push_back(8'h0D);
      ch.push_back(8'h0A);
    end else begin
      ch.push_back(8'h20);
    end
`else
    ch.push_back(b);
`endif
    m_nf = ch.size();
  endfunction

  // line level at offset 'off' cycles after the pop cycle
  function automatic logic exp_tx(int off);
    int j, f, w, b;
    logic [7:0] c;
    if (off < 2) return 1'b1;
    j = off - 2;
    f = j / P;
    w = j % P;
    if (w == 10 * D) return 1'b1;
    b = w / D;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    c = ch[f];
    return c[b-1];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (rrst_n) m_arm = 1;
    if (m_off >= 0) m_off++;
    if (m_off == 2 + m_nf * P) begin
      m_off = -1;
      m_cnt++;
      m_line = (m_line == BPL - 1) ? 0 : m_line + 1;
    end
    if (m_pend) begin
      m_pend = 0;
      m_off = 0;
      m_byte = fq.pop_front();
      load_chars(m_byte);
      if (first_pop < 0) first_pop = cyc;
    end
    if (rrst_n) begin
      chk("rinc", ff.fifo_rinc, (m_off == 0));
      chk("busy", busy, (m_off >= 0));
      chk("tx", uart_tx, (m_off >= 0) ? exp_tx(m_off) : 1'b1);
      chk("byte_cnt", byte_cnt, m_cnt);
      n_rinc += int'(ff.fifo_rinc);
      n_txlo += int'(!uart_tx);
      n_busy += int'(busy);
      if (byte_cnt != prev_cnt) cnt_cyc = cyc;
      prev_cnt = byte_cnt;
      if (rx_cnt >= 0) begin
        rx_cnt++;
        if (rx_cnt < 9 * D && rx_cnt % D == D / 2)
          rx_sh[rx_cnt / D - 1] = uart_tx;
        if (rx_cnt == 9 * D + D / 2) begin
          chk("stop_bit", uart_tx, 1'b1);
          rxq.push_back(rx_sh);
          rx_cnt = -1;
        end
      end else if (uart_tx == 1'b0) begin
        rx_cnt = 0;
      end
    end
    ff.fifo_rdata  = (m_off == 1) ? m_byte : 8'($urandom);
    ff.fifo_rempty = (fq.size() == 0);
    m_pend = rrst_n && (m_off == -1) && m_arm && !ff.fifo_rempty;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    #1;
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rinc", ff.fifo_rinc, 1'b0);
    chk("rst_cnt", byte_cnt, 16'd0);
    m_off = -1; m_pend = 0; m_arm = 0;
    m_cnt = 0; m_line = 0; prev_cnt = 0;
    rx_cnt = -1; rxq.delete(); ch.delete();
    repeat (3) cycle();
  endtask

  task automatic release_rst();
    rrst_n = 1'b1;
    m_arm = 0;
    cyc = 0;
    first_pop = -1;
    cnt_cyc = -1;
    n_rinc = 0; n_txlo = 0; n_busy = 0;
  endtask

  task automatic wait_cnt(int n, int budget);
    int k = 0;
    while (m_cnt != 16'(n) && k < budget) begin
      cycle();
      k++;
    end
    chk("wait_done", (m_cnt == 16'(n)), 1'b1);
    repeat (2) cycle();
  endtask

  task automatic chk_rx(string name, logic [7:0] exp[$]);
    chk({name, "_len"}, rxq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rxq.size(); i++)
      chk(name, rxq[i], exp[i]);
  endtask

  initial begin
    logic [7:0] e[$];
    int n;
    int tgt;
    int k;
    ff.fifo_rempty = 1'b1;
    ff.fifo_rdata  = 8'h00;

    do_reset();
    release_rst();
    repeat (1000) cycle();
    chk("idle_rinc", n_rinc, 0);
    chk("idle_txlo", n_txlo, 0);
    chk("idle_busy", n_busy, 0);

    do_reset();
    fq.push_back(8'hA5);
    cycle();
    release_rst();
    wait_cnt(1, 400);
    chk("first_pop", first_pop, 2);
`ifdef FIFO_HEX_UART_HEX_EN
    chk("a5_dur", cnt_cyc - first_pop, 125);
    e = '{8'h41, 8'h35, 8'h20};
`else
    chk("a5_dur", cnt_cyc - first_pop, 43);
    e = '{8'hA5};
`endif
    chk_rx("a5_chars", e);

    do_reset();
    for (int i = 0; i < 5; i++) fq.push_back(8'(i));
    release_rst();
    wait_cnt(5, 2000);
`ifdef FIFO_HEX_UART_HEX_EN
    e = '{8'h30, 8'h30, 8'h20, 8'h30, 8'h31, 8'h20,
          8'h30, 8'h32, 8'h20, 8'h30, 8'h33, 8'h0D,
          8'h0A, 8'h30, 8'h34, 8'h20};
    chk("line_cnt", 32'(dut.r_line), 1);
`else
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
    chk_rx("line_chars", e);

    do_reset();
    fq.push_back(8'h3C);
    fq.push_back(8'h7E);
    release_rst();
`ifdef FIFO_HEX_UART_HEX_EN
    tgt = 2 + P + 3 * D;
`else
    tgt = 2 + 3 * D;
`endif
    k = 0;
    while (m_off != tgt && k < 500) begin
      cycle();
      k++;
    end
    chk("mid_reach", m_off, tgt);
    do_reset();
    release_rst();
    wait_cnt(1, 400);
`ifdef FIFO_HEX_UART_HEX_EN
    e = '{8'h37, 8'h45, 8'h20};
`else
    e = '{8'h7E};
`endif
    chk_rx("after_rst", e);

    do_reset();
    release_rst();
    n = 0;
    for (int c = 0; c < 6000; c++) begin
      if (fq.size() < 3 && $urandom_range(0, 39) == 0) begin
        fq.push_back(8'($urandom));
        n++;
      end
      cycle();
    end
    wait_cnt(n, 200 * (fq.size() + 2));
    chk("rand_cnt", byte_cnt, 16'(n));
`ifdef FIFO_HEX_UART_HEX_EN
    chk("rand_chars", rxq.size(), 3 * n + n / BPL);
`else
    chk("rand_chars", rxq.size(), n);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
